// File: rtl/pulse_period_checker.sv
// pulse_period_checker
//
// Receive-side monitor for a periodic single-cycle strobe. It measures the
// number of clock cycles between strobes. It locks once the same interval has
// repeated LOCK_COUNT times after the first measurement. After lock it flags
// a change of period or a missing strobe.
//
// Ports:
//   clk          in   sole clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   pulse_in     in   strobe under test, synchronous to clk
//   period       out  last measured interval in cycles (registered)
//   period_valid out  one-cycle pulse after each new measurement
//   locked       out  level, high while in LOCKED
//   err          out  one-cycle pulse: mismatch or timeout while locked
//   state_o      out  current FSM state (IDLE=0, ARM=1, TRACK=2, LOCKED=3)
module pulse_period_checker #(
  parameter int MAX_PERIOD = 15,
  parameter int CNT_W      = 4,
  parameter int LOCK_COUNT = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARM    = 2'b01,
    TRACK  = 2'b10,
    LOCKED = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PERIOD);
  localparam logic [4:0]       LOCK_TGT = 5'(LOCK_COUNT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             err_q, err_d;
  logic [4:0]       match_inc;

  // One extra bit so the comparison with LOCK_COUNT cannot alias on wrap.
  assign match_inc = {1'b0, match_cnt_q} + 5'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      match_cnt_q    <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      match_cnt_q    <= match_cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      err_q          <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    match_cnt_d    = match_cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    err_d          = 1'b0;

    if (state_q == IDLE) begin
      cnt_d = '0;
      if (pulse_in) begin
        cnt_d   = CNT_W'(1);
        state_d = ARM;
      end
    end else if (pulse_in) begin
      // A strobe always closes the current interval, even when cnt has
      // reached MAX_PERIOD: that is a valid measurement, not a timeout.
      cnt_d          = CNT_W'(1);
      period_valid_d = 1'b1;
      case (state_q)
        ARM: begin
          period_d    = cnt_q;
          match_cnt_d = '0;
          state_d     = TRACK;
        end
        TRACK: begin
          if (cnt_q == period_q) begin
            match_cnt_d = match_inc[3:0];
            if (match_inc == LOCK_TGT) state_d = LOCKED;
          end else begin
            period_d    = cnt_q;
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          // match_cnt holds while locked.
          if (cnt_q != period_q) begin
            err_d       = 1'b1;
            period_d    = cnt_q;
            match_cnt_d = '0;
            state_d     = TRACK;
          end
        end
        default: ;
      endcase
    end else if (cnt_q == MAX_CNT) begin
      // Timeout: period keeps its last value; only a lost lock is an error.
      err_d   = (state_q == LOCKED);
      cnt_d   = '0;
      state_d = IDLE;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = (state_q == LOCKED);
  assign err          = err_q;
  assign state_o      = state_q;

endmodule

// File: doc/pulse_period_checker.md
# pulse_period_checker

Receive-side monitor for periodic single-cycle strobes such as a divide-by-N "tick" output. It measures the clock-cycle interval between strobes and locks once the interval is stable. After lock it flags a change of period or a missing strobe. It sits downstream of clock-divider FSMs as a self-check and rate detector.

## Interface
- `MAX_PERIOD`, default 15: longest interval, in cycles, that is accepted. Longer gaps are a timeout.
- `CNT_W`, default 4: width of the counter and of `period`. Must hold `MAX_PERIOD`.
- `LOCK_COUNT`, default 2: number of consecutive matching intervals, counted after the first interval, needed to lock. Range 1..15.
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pulse_in`  in  1  strobe under test. Synchronous to `clk`, sampled every rising edge.
- `period`  out  CNT_W  last measured interval in cycles (registered).
- `period_valid`  out  1  one-cycle pulse, high in the cycle after each new measurement.
- `locked`  out  1  level, high while in LOCKED.
- `err`  out  1  one-cycle pulse: period mismatch or timeout while locked.
- `state_o`  out  2  current FSM state, for debug.

## Operation
- States and encodings: IDLE=00, ARM=01, TRACK=10, LOCKED=11.
- Internal registers:
  - `cnt` (CNT_W bits): cycles since the last strobe.
  - `match_cnt` (4 bits).
  - `period`.
- In ARM, TRACK and LOCKED with `pulse_in`=0, `cnt` increments by 1.
- Any sampled strobe in ARM/TRACK/LOCKED loads `cnt` to 1. The measured interval equals `cnt` at that edge, so strobes every 3 cycles give a measurement of 3.
- IDLE:
  - `cnt` is held at 0.
  - On `pulse_in`=1: `cnt`←1, go to ARM.
- ARM, on strobe:
  - `period`←`cnt`, `match_cnt`←0, assert `period_valid`.
  - Go to TRACK. No comparison is made.
- TRACK, on strobe:
  - Assert `period_valid`.
  - If `cnt`==`period`, `match_cnt`←`match_cnt`+1. When the incremented value equals `LOCK_COUNT`, go to LOCKED.
  - If `cnt`≠`period`, `period`←`cnt`, `match_cnt`←0, stay in TRACK.
- LOCKED, on strobe:
  - Assert `period_valid`.
  - If `cnt`==`period`, stay in LOCKED.
  - If `cnt`≠`period`, assert `err`, `period`←`cnt`, `match_cnt`←0, go to TRACK.
- Timeout applies in ARM, TRACK and LOCKED. It fires when `cnt`==`MAX_PERIOD` and `pulse_in`=0:
  - Go to IDLE and set `cnt`←0. `period` keeps its last value.
  - Assert `err` only if the state was LOCKED.
- Strobe on the timeout edge: if `cnt`==`MAX_PERIOD` and `pulse_in`=1, it is a valid measurement of `MAX_PERIOD`. No timeout occurs.
- Held-high input: a continuously high `pulse_in` is a strobe every cycle, so it measures period 1 and can lock at period 1.
- `cnt` never wraps. Timeout fires before `cnt` exceeds `MAX_PERIOD`.
- `match_cnt` saturates and holds in LOCKED.

## Timing
- Reset (`reset_n`=0, asynchronous, effective immediately):
  - state=IDLE.
  - `cnt`=0, `match_cnt`=0.
  - `period`=0, `period_valid`=0, `locked`=0, `err`=0.
- Reset mid-measurement or mid-lock discards everything. After release, the first sampled strobe is treated as in IDLE.
- All outputs are registered. `period_valid`, `err` and `locked` change on the same edge that samples the deciding strobe, or on the timeout edge, so they are visible in the following cycle.
- `period_valid` and `err` are high for exactly one cycle per event. They can be high together, on a LOCKED mismatch.
- Lock latency: with period P and the first strobe sampled at edge E0, `locked` rises at edge E0 + (LOCK_COUNT+1)·P.
- Loss of lock, mismatch: `locked` falls on the edge of the mismatching strobe.
- Loss of lock, timeout: `locked` falls on the edge where `cnt`==`MAX_PERIOD` with no strobe, which is `MAX_PERIOD` cycles after the last strobe.

## Test plan
- Divide-by-3 strobe (pulse at edges 0, 3, 6, 9, …), defaults:
  - `period_valid` at edges 3, 6, 9.
  - `period`=3 from edge 3.
  - `locked` rises at edge 9.
  - `err` never asserted.
- Locked at 3, then the next gap is 4 cycles:
  - `err` and `period_valid` pulse together, `period`=4, `locked`=0, state=TRACK.
  - Two further 4-cycle gaps bring `locked`=1 again.
- Locked at 3, then strobes stop:
  - 15 cycles after the last strobe: `err`=1 for one cycle, `locked`=0, state=IDLE, `period` stays 3.
- Strobes with a 15-cycle gap: valid measurement, `period`=15, no timeout.
- Strobes with a 16-cycle gap while in TRACK: return to IDLE with no `err`.
- `pulse_in` held high from reset release:
  - `period`=1, `locked` high 3 cycles after the first sampled strobe.
- Assert `reset_n`=0 in LOCKED for a partial cycle:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, a period-5 stream relocks at the first strobe + 15 cycles.
